// File: rtl/divisor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : divisor_pkg
// Description : Shared constants and state encoding for the restoring divider.
//               N_DEF   - default operand width (divisor/quotient width)
//               CNT_W   - iteration counter width for N_DEF
//               estado_t - controller states
// Revision    : 1.0 - initial release
// ============================================================================
package divisor_pkg;

   localparam int N_DEF = 16;
   localparam int CNT_W = $clog2(N_DEF);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } estado_t;

endpackage
`default_nettype wire

// File: rtl/divisor_if.sv
`default_nettype none
// ============================================================================
// Module      : divisor_if
// Description : Operand/result bundle of the divider.
//               st        - start request (master -> slave)
//               dividendo - 2N-bit unsigned dividend (master -> slave)
//               divisor   - N-bit unsigned divisor (master -> slave)
//               idle      - ready for a new start (slave -> master)
//               done      - one-cycle result-valid pulse (slave -> master)
//               quociente - N-bit quotient (slave -> master)
//               resto     - N-bit remainder (slave -> master)
//               ovf       - overflow / divide-by-zero flag (slave -> master)
// Revision    : 1.0 - initial release
// ============================================================================
interface divisor_if #(
   parameter int N = 16
);
   logic           st;
   logic [2*N-1:0] dividendo;
   logic [N-1:0]   divisor;
   logic           idle;
   logic           done;
   logic [N-1:0]   quociente;
   logic [N-1:0]   resto;
   logic           ovf;

   modport master (
      output st, dividendo, divisor,
      input  idle, done, quociente, resto, ovf
   );

   modport slave (
      input  st, dividendo, divisor,
      output idle, done, quociente, resto, ovf
   );
endinterface
`default_nettype wire

// File: rtl/divisor_passo.sv
`default_nettype none
// ============================================================================
// Module      : div_passo
// Description : One combinational restoring-division step. Compares the
//               N+1-bit partial remainder with the divisor and, when it is
//               not smaller, subtracts.
// Ports       : parcial_i - N+1-bit partial remainder after the shift
//               divisor_i - N-bit divisor
//               resto_o   - N-bit remainder for the next iteration
//               bit_o     - quotient bit produced by this step
// Revision    : 1.0 - initial release
// ============================================================================
module div_passo #(
   parameter int N = 16
) (
   input  wire logic [N:0]   parcial_i,
   input  wire logic [N-1:0] divisor_i,
   output logic      [N-1:0] resto_o,
   output logic              bit_o
);

   logic [N:0] w_dvs_ext;
   logic [N:0] w_dif;

   assign w_dvs_ext = {1'b0, divisor_i};
   assign w_dif     = parcial_i - w_dvs_ext;
   assign bit_o     = (parcial_i >= w_dvs_ext);
   // Remainder stays below the divisor, so the top bit is always zero after
   // a successful subtract and can be dropped.
   assign resto_o   = bit_o ? w_dif[N-1:0] : parcial_i[N-1:0];

endmodule
`default_nettype wire

// File: rtl/divisor.sv
`default_nettype none
// ============================================================================
// Module      : divisor
// Description : Sequential restoring divider, 2N-bit / N-bit unsigned, one
//               quotient bit per clock. Overflow (high half of the dividend
//               not below the divisor, including divide-by-zero) is detected
//               at start and reported without iterating.
// Ports       : clk_i   - clock, rising edge
//               rst_n_i - synchronous active-low reset
//               bus     - divisor_if.slave (start/operands in, results out)
// Revision    : 1.0 - initial release
// ============================================================================
module divisor
   import divisor_pkg::*;
#(
   parameter int N = N_DEF
) (
   input wire logic  clk_i,
   input wire logic  rst_n_i,
   divisor_if.slave  bus
);

   localparam int             CW     = $clog2(N);
   localparam logic [CW-1:0]  C_LAST = CW'(N - 1);

   estado_t        state_q, state_d;
   logic [CW-1:0]  cnt_q,   cnt_d;
   logic [N-1:0]   rem_q,   rem_d;    // working partial remainder
   logic [N-1:0]   quo_q,   quo_d;    // working low dividend / quotient bits
   logic [N-1:0]   dvs_q,   dvs_d;    // captured divisor
   logic [N-1:0]   qout_q,  qout_d;   // quotient presented at the port
   logic [N-1:0]   rout_q,  rout_d;   // remainder presented at the port
   logic           ovf_q,   ovf_d;

   logic [N:0]     w_parcial;
   logic [N-1:0]   w_resto;
   logic           w_bit;

   // Shift {remainder, quotient} left by one: the quotient MSB moves into
   // the remainder LSB to form the N+1-bit partial remainder.
   assign w_parcial = {rem_q, quo_q[N-1]};

   div_passo #(.N(N)) u_passo (
      .parcial_i (w_parcial),
      .divisor_i (dvs_q),
      .resto_o   (w_resto),
      .bit_o     (w_bit)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      qout_d  = qout_q;
      rout_d  = rout_q;
      ovf_d   = ovf_q;
      case (state_q)
         S_IDLE: begin
            if (bus.st) begin
               rem_d = bus.dividendo[2*N-1:N];
               quo_d = bus.dividendo[N-1:0];
               dvs_d = bus.divisor;
               cnt_d = '0;
               ovf_d = 1'b0;
               // A quotient wider than N bits (or a zero divisor) cannot be
               // represented; report it immediately.
               if (bus.dividendo[2*N-1:N] >= bus.divisor) begin
                  ovf_d   = 1'b1;
                  qout_d  = '1;
                  rout_d  = '0;
                  state_d = S_DONE;
               end else begin
                  state_d = S_CALC;
               end
            end
         end
         S_CALC: begin
            rem_d = w_resto;
            quo_d = {quo_q[N-2:0], w_bit};
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == C_LAST) begin
               // Port results change only on entry to DONE.
               qout_d  = {quo_q[N-2:0], w_bit};
               rout_d  = w_resto;
               state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         dvs_q   <= '0;
         qout_q  <= '0;
         rout_q  <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dvs_q   <= dvs_d;
         qout_q  <= qout_d;
         rout_q  <= rout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bus.idle      = (state_q == S_IDLE);
   assign bus.done      = (state_q == S_DONE);
   assign bus.quociente = qout_q;
   assign bus.resto     = rout_q;
   assign bus.ovf       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_divisor.sv
`default_nettype none
// ============================================================================
// Module      : tb_divisor
// Description : Directed self-checking bench for the divisor block.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_divisor;

   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_err;
   logic [15:0] last_q;
   logic [15:0] last_r;

   divisor_if #(.N(16)) bus ();

   divisor #(.N(16)) dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.st = 1'b1;            // reset must win over start
      bus.dividendo = 32'd100;
      bus.divisor = 16'd7;
      tick();
      tick();
      n_vec++;
      if (bus.idle !== 1'b1 || bus.done !== 1'b0 || bus.ovf !== 1'b0 ||
          bus.quociente !== 16'd0 || bus.resto !== 16'd0) begin
         n_err++;
         $display("FAIL reset: idle=%b done=%b ovf=%b q=%h r=%h, required 1 0 0 0000 0000",
                  bus.idle, bus.done, bus.ovf, bus.quociente, bus.resto);
      end
      bus.st = 1'b0;
      rst_n = 1'b1;
      tick();
      last_q = 16'd0;
      last_r = 16'd0;
   endtask

   // Pulse start, wait for done, check latency, Idle-low span, results,
   // that the ports hold during CALC, and the return to IDLE.
   task automatic run_op(input string nm, input logic [31:0] dvd, input logic [15:0] dvs,
                         input logic [15:0] eq, input logic [15:0] er, input logic eovf,
                         input int elat);
      int lat;
      int lowcnt;
      bit hold_bad;
      bus.st = 1'b1;
      bus.dividendo = dvd;
      bus.divisor = dvs;
      tick();
      bus.st = 1'b0;
      bus.dividendo = ~dvd;     // later operand changes must not matter
      bus.divisor = ~dvs;
      lat = 1;
      lowcnt = 0;
      hold_bad = 0;
      while (1) begin
         if (!bus.idle) lowcnt++;
         if (bus.done) break;
         if (bus.quociente !== last_q || bus.resto !== last_r || bus.ovf !== 1'b0)
            hold_bad = 1;
         if (lat > 100) break;
         tick();
         lat++;
      end
      n_vec++;
      if (lat !== elat) begin
         n_err++;
         $display("FAIL %s latency: got %0d edges, required %0d", nm, lat, elat);
      end
      n_vec++;
      if (lowcnt !== elat) begin
         n_err++;
         $display("FAIL %s idle_low: got %0d cycles, required %0d", nm, lowcnt, elat);
      end
      n_vec++;
      if (hold_bad) begin
         n_err++;
         $display("FAIL %s hold: ports changed during CALC, required q=%h r=%h ovf=0",
                  nm, last_q, last_r);
      end
      n_vec++;
      if (bus.quociente !== eq || bus.resto !== er || bus.ovf !== eovf) begin
         n_err++;
         $display("FAIL %s result: q=%h r=%h ovf=%b, required q=%h r=%h ovf=%b",
                  nm, bus.quociente, bus.resto, bus.ovf, eq, er, eovf);
      end
      tick();
      n_vec++;
      if (bus.idle !== 1'b1 || bus.done !== 1'b0 || bus.quociente !== eq ||
          bus.resto !== er || bus.ovf !== eovf) begin
         n_err++;
         $display("FAIL %s post_done: idle=%b done=%b q=%h r=%h ovf=%b, required 1 0 %h %h %b",
                  nm, bus.idle, bus.done, bus.quociente, bus.resto, bus.ovf, eq, er, eovf);
      end
      last_q = eq;
      last_r = er;
   endtask

   task automatic test_basic();
      run_op("basic_100_7", 32'd100, 16'd7, 16'd14, 16'd2, 1'b0, 17);
      run_op("basic_1000_33", 32'd1000, 16'd33, 16'd30, 16'd10, 1'b0, 17);
   endtask

   task automatic test_max();
      run_op("max", 32'hFFFE0001, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 17);
      run_op("max_rem", 32'h0001FFFF, 16'h0002, 16'hFFFF, 16'h0001, 1'b0, 17);
   endtask

   task automatic test_overflow();
      run_op("div_by_zero", 32'd5, 16'd0, 16'hFFFF, 16'h0000, 1'b1, 1);
      run_op("ovf_hi_eq", 32'h00010000, 16'd1, 16'hFFFF, 16'h0000, 1'b1, 1);
   endtask

   task automatic test_back_to_back();
      int guard;
      int idle_between;
      bus.st = 1'b1;
      bus.dividendo = 32'd225;
      bus.divisor = 16'd15;
      guard = 0;
      tick();
      while (!bus.done && guard < 100) begin
         tick();
         guard++;
      end
      n_vec++;
      if (bus.done !== 1'b1 || bus.quociente !== 16'd15 || bus.resto !== 16'd0 || bus.ovf !== 1'b0) begin
         n_err++;
         $display("FAIL b2b_first: done=%b q=%h r=%h ovf=%b, required 1 000f 0000 0",
                  bus.done, bus.quociente, bus.resto, bus.ovf);
      end
      idle_between = 0;
      guard = 0;
      tick();
      if (bus.idle) idle_between++;
      tick();   // new start edge with st still high
      tick();
      tick();
      bus.dividendo = 32'd1000; // mid-CALC change must be ignored
      bus.divisor = 16'd3;
      while (!bus.done && guard < 100) begin
         if (bus.idle) idle_between++;
         tick();
         guard++;
      end
      bus.st = 1'b0;
      n_vec++;
      if (idle_between !== 1) begin
         n_err++;
         $display("FAIL b2b_gap: got %0d idle cycles between done pulses, required 1", idle_between);
      end
      n_vec++;
      if (bus.done !== 1'b1 || bus.quociente !== 16'd15 || bus.resto !== 16'd0 || bus.ovf !== 1'b0) begin
         n_err++;
         $display("FAIL b2b_second: done=%b q=%h r=%h ovf=%b, required 1 000f 0000 0",
                  bus.done, bus.quociente, bus.resto, bus.ovf);
      end
      tick();
      tick();
      n_vec++;
      if (bus.idle !== 1'b1 || bus.done !== 1'b0) begin
         n_err++;
         $display("FAIL b2b_stop: idle=%b done=%b, required 1 0", bus.idle, bus.done);
      end
      last_q = 16'd15;
      last_r = 16'd0;
   endtask

   task automatic test_reset_calc();
      bit saw_done;
      bus.st = 1'b1;
      bus.dividendo = 32'd100;
      bus.divisor = 16'd7;
      tick();                   // start edge
      bus.st = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      rst_n = 1'b0;
      tick();                   // edge 8 of the operation
      n_vec++;
      if (bus.idle !== 1'b1 || bus.done !== 1'b0 || bus.ovf !== 1'b0 ||
          bus.quociente !== 16'd0 || bus.resto !== 16'd0) begin
         n_err++;
         $display("FAIL reset_calc: idle=%b done=%b ovf=%b q=%h r=%h, required 1 0 0 0000 0000",
                  bus.idle, bus.done, bus.ovf, bus.quociente, bus.resto);
      end
      rst_n = 1'b1;
      saw_done = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (bus.done) saw_done = 1;
      end
      n_vec++;
      if (saw_done) begin
         n_err++;
         $display("FAIL reset_abort: got a done pulse after reset, required none");
      end
      last_q = 16'd0;
      last_r = 16'd0;
      run_op("after_reset", 32'd20, 16'd2, 16'd10, 16'd0, 1'b0, 17);
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst_n = 1'b0;
      bus.st = 1'b0;
      bus.dividendo = '0;
      bus.divisor = '0;
      last_q = '0;
      last_r = '0;
      test_reset();
      test_basic();
      test_max();
      test_overflow();
      test_back_to_back();
      test_reset_calc();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
